// File: rtl/uart_rx_ovs_if.sv
// rtl/uart_rx_ovs_if.sv - received-word handshake bundle between the UART receiver and its consumer
//
// Signals:
//   rx_data    received word, LSB first on the line
//   rx_valid   rx_data and the status flags are valid
//   rx_ready   consumer accepts the word
//   frame_err  stop bit sampled low (qualified by rx_valid)
//   parity_err parity mismatch (qualified by rx_valid)
//   overrun    one-cycle pulse: a completed frame was dropped
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_ovs_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - oversampling UART receiver with majority-vote bit decisions
//
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   rxd    asynchronous serial line, idles high
//   busy   receiver FSM is not in IDLE
//   rx_if  uart_rx_ovs_if.master: rx_data/rx_valid/rx_ready/frame_err/parity_err/overrun
module uart_rx_ovs #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 38400,
  parameter int OVS      = 8,
  parameter int DATA_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  output logic           busy,
  uart_rx_ovs_if.master  rx_if
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVS);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SMP_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W);

  // Sample-count landmarks within one bit; SMP_END wraps modulo OVS (0 when OVS=4).
  localparam logic [SMP_W-1:0] SMP_V0   = SMP_W'(OVS / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_V1   = SMP_W'(OVS / 2);
  localparam logic [SMP_W-1:0] SMP_V2   = SMP_W'(OVS / 2 + 1);
  localparam logic [SMP_W-1:0] SMP_END  = SMP_W'(OVS / 2 + 2);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t            state_q;
  logic              rxd_s1_q, rxd_s2_q;
  logic [DIV_W-1:0]  div_q;
  logic [SMP_W-1:0]  smp_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              v0_q, v1_q;
  logic              ferr_pend_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ferr_q;
  logic              ovr_q;
  logic              tick;
  logic              vote;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // Free-running oversampling divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == DIV_LAST);

  // Majority of the two stored samples and the live third sample; only used at SMP_V2.
  assign vote = (v0_q & v1_q) | (v0_q & rxd_s2_q) | (v1_q & rxd_s2_q);

`ifdef UART_RX_PARITY_EN
  logic perr_pend_q;
  logic perr_q;
  assign rx_if.parity_err = perr_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      smp_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      ferr_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      ovr_q <= 1'b0;
      // A load later in this block overrides this clear, keeping rx_valid high.
      if (valid_q && rx_if.rx_ready) valid_q <= 1'b0;
      if (tick) begin
        smp_q <= smp_q + 1'b1;
        if (smp_q == SMP_V0) v0_q <= rxd_s2_q;
        if (smp_q == SMP_V1) v1_q <= rxd_s2_q;
        case (state_q)
          IDLE: begin
            if (!rxd_s2_q) begin
              smp_q   <= '0;
              state_q <= START;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (smp_q == SMP_V2 && vote) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (smp_q == SMP_LAST) begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end
          DATA: begin
            if (smp_q == SMP_V2) shift_q <= {vote, shift_q[DATA_W-1:1]};
            if (smp_q == SMP_LAST) begin
              if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (smp_q == SMP_V2) perr_pend_q <= vote ^ (^shift_q);
            if (smp_q == SMP_LAST) state_q <= STOP;
          end
`endif
          STOP: begin
            if (smp_q == SMP_V2) ferr_pend_q <= ~vote;
            // Leave one tick after the vote so the next start edge is seen on time.
            if (smp_q == SMP_END) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (!valid_q || rx_if.rx_ready) begin
                data_q  <= shift_q;
                ferr_q  <= ferr_pend_q;
                valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                perr_q  <= perr_pend_q;
`endif
              end else begin
                ovr_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy            = busy_q;
  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - directed self-checking bench for uart_rx_ovs
module tb_uart_rx_ovs;

  localparam int BAUD     = 38400;
  localparam int OVS      = 8;
  localparam int DATA_W   = 8;
  localparam int CLK_FREQ = BAUD * OVS * 4;
  localparam int BIT_CLKS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic busy;

  uart_rx_ovs_if #(.DATA_W(DATA_W)) rx_if ();

  uart_rx_ovs #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .OVS     (OVS),
    .DATA_W  (DATA_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rxd  (rxd),
    .busy (busy),
    .rx_if(rx_if)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  int valid_cycles = 0;
  int acc_cnt = 0;
  int ovr_cnt = 0;
  logic [DATA_W-1:0] last_data = '0;
  logic last_ferr = 1'b0;
  logic last_perr = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.rx_valid) valid_cycles++;
      if (rx_if.overrun) ovr_cnt++;
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        acc_cnt++;
        last_data = rx_if.rx_data;
        last_ferr = rx_if.frame_err;
        last_perr = rx_if.parity_err;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input logic par, input logic stop);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < DATA_W; i++) begin
      rxd = data[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par;
    wait_clks(BIT_CLKS);
`else
    if (par) rxd = 1'b1;
`endif
    rxd = stop;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
  endtask

  task automatic handshake();
    rx_if.rx_ready = 1'b1;
    wait_clks(1);
    rx_if.rx_ready = 1'b0;
  endtask

  int acc0;
  int vc0;
  int ov0;

  initial begin
    rx_if.rx_ready = 1'b0;
    wait_clks(3);
    check("rst_valid",  rx_if.rx_valid,   0);
    check("rst_busy",   busy,             0);
    check("rst_ovr",    rx_if.overrun,    0);
    check("rst_data",   rx_if.rx_data,    0);
    check("rst_ferr",   rx_if.frame_err,  0);
    check("rst_perr",   rx_if.parity_err, 0);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);

    // Plain 0xA5 with consumer always ready.
    rx_if.rx_ready = 1'b1;
    acc0 = acc_cnt; vc0 = valid_cycles;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    wait_clks(2 * BIT_CLKS);
    check("a5_accepts", acc_cnt - acc0, 1);
    check("a5_vcycles", valid_cycles - vc0, 1);
    check("a5_data",    last_data, 8'hA5);
    check("a5_ferr",    last_ferr, 0);
    check("a5_perr",    last_perr, 0);

    // Two-tick low glitch in IDLE.
    acc0 = acc_cnt;
    rxd = 1'b0;
    wait_clks(8);
    rxd = 1'b1;
    check("glitch_busy_hi", busy, 1);
    wait_clks(BIT_CLKS);
    check("glitch_busy_lo", busy, 0);
    wait_clks(BIT_CLKS);
    check("glitch_no_word", acc_cnt - acc0, 0);

    // Consumer stalled: 0x11 then 0x22 back-to-back.
    rx_if.rx_ready = 1'b0;
    wait_clks(2);
    acc0 = acc_cnt; ov0 = ovr_cnt;
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    wait_clks(2 * BIT_CLKS);
    check("ovr_valid",   rx_if.rx_valid, 1);
    check("ovr_data",    rx_if.rx_data, 8'h11);
    check("ovr_pulses",  ovr_cnt - ov0, 1);
    check("ovr_no_acc",  acc_cnt - acc0, 0);
    handshake();
    check("ovr_cleared", rx_if.rx_valid, 0);
    check("ovr_acc_data", last_data, 8'h11);

    // Stop bit forced low.
    send_frame(8'h3C, ^8'h3C, 1'b0);
    wait_clks(2 * BIT_CLKS);
    check("ferr_valid", rx_if.rx_valid, 1);
    check("ferr_data",  rx_if.rx_data, 8'h3C);
    check("ferr_flag",  rx_if.frame_err, 1);
    handshake();
    check("ferr_cleared", rx_if.rx_valid, 0);
    check("ferr_no_ovr",  ovr_cnt - ov0, 1);

`ifdef UART_RX_PARITY_EN
    rx_if.rx_ready = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1);
    wait_clks(2 * BIT_CLKS);
    check("par_bad_err",  last_perr, 1);
    check("par_bad_data", last_data, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(2 * BIT_CLKS);
    check("par_good_err", last_perr, 0);
    rx_if.rx_ready = 1'b0;
    wait_clks(2);
`endif

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x5A.
    rx_if.rx_ready = 1'b1;
    acc0 = acc_cnt;
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
    wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    wait_clks(3);
    check("midrst_busy",  busy, 0);
    check("midrst_valid", rx_if.rx_valid, 0);
    rst = 1'b0;
    wait_clks(8 * BIT_CLKS);
    check("midrst_idle", busy, 0);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    wait_clks(2 * BIT_CLKS);
    check("midrst_acc",  acc_cnt - acc0, 1);
    check("midrst_data", last_data, 8'h5A);
    check("midrst_ferr", last_ferr, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 38400: line bit rate in bit/s.
REQ-003 SHALL have parameter OVS, default 8: oversampling factor; legal values 4, 8, 16.
REQ-004 SHALL have parameter DATA_W, default 8: data bits per frame; legal range 5..16.
REQ-005 SHALL have port clk, input, 1: system clock; reset rst, asynchronous, active-high; clock clk.
REQ-006 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port rxd, input, 1: asynchronous serial line; idles high.
REQ-008 SHALL have port rx_data, output, DATA_W: received word, LSB first on the line.
REQ-009 SHALL have port rx_valid, output, 1: rx_data and status flags are valid.
REQ-010 SHALL have port rx_ready, input, 1: consumer accepts the word.
REQ-011 SHALL have port frame_err, output, 1: stop bit sampled low; qualified by rx_valid.
REQ-012 SHALL have port parity_err, output, 1: parity mismatch; qualified by rx_valid.
REQ-013 SHALL have port overrun, output, 1: one-cycle pulse; a completed frame was dropped.
REQ-014 SHALL have port busy, output, 1: FSM is not in IDLE.

Function
REQ-015 SHALL pass rxd through a 2-flop synchronizer, reset to 1; all sampling uses the synchronized value.
REQ-016 SHALL derive DIV = CLK_FREQ/(BAUD*OVS), truncated (325 at defaults); the divider emits a 1-clk tick every DIV clocks and runs freely.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; all transitions occur only on tick.
REQ-018 SHALL, in IDLE on a tick with synchronized rxd=0, clear the sample counter and go to START.
REQ-019 SHALL decide each bit by majority vote of samples at sample counts OVS/2-1, OVS/2 and OVS/2+1 within the bit.
REQ-020 SHALL, in START, return to IDLE with no output if the start-bit vote is 1 (glitch rejection); otherwise go to DATA at sample count OVS-1.
REQ-021 SHALL, in DATA, shift DATA_W voted bits LSB first, then go to PARITY (macro defined) or STOP.
REQ-022 SHALL, in PARITY, compare the voted bit against even parity over the data bits.
REQ-023 SHALL, in STOP, return to IDLE on the tick after the vote (sample count OVS/2+1), so that back-to-back frames are accepted with one stop bit.
REQ-024 SHALL, at STOP completion, load rx_data, frame_err and parity_err and set rx_valid on the next clk edge, but only if rx_valid=0 or rx_ready=1 in that cycle.
REQ-025 SHALL, if the word cannot be loaded, drop it, retain the old word and flags, and pulse overrun for 1 clk.
REQ-026 SHALL deassert rx_valid after any clk in which rx_valid && rx_ready, unless a new word loads in that same cycle, in which case rx_valid stays 1.
REQ-027 SHALL deliver frames with frame_err=1 normally; the FSM does not wait for the line to go high.

Reset
REQ-028 SHALL, on rst, clear FSM to IDLE, divider, sample and bit counters, rx_data, rx_valid, frame_err, parity_err, overrun and busy to 0, and set synchronizer flops to 1.
REQ-029 SHALL, on rst asserted mid-frame, discard the frame and then wait for a fresh falling edge after release.

Configuration
REQ-030 SHALL, with UART_RX_PARITY_EN defined, include the PARITY state, so that a frame is start + DATA_W + parity + stop.
REQ-031 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and parity logic, so that a frame is start + DATA_W + stop, and tie parity_err to 0.

Verification
REQ-032 SHALL cover: defaults, no parity, send 0xA5 at 38400 baud with rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, frame_err=0.
REQ-033 SHALL cover: rxd low pulse of 2 ticks in IDLE -> no rx_valid, busy returns to 0 within one bit time.
REQ-034 SHALL cover: rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun pulses once, then handshake -> rx_valid=0.
REQ-035 SHALL cover: send 0x3C with stop bit forced 0 -> rx_valid=1, rx_data=0x3C, frame_err=1.
REQ-036 SHALL cover: UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-037 SHALL cover: rst asserted during data bit 4 of 0xFF, then 0x5A sent after release -> only 0x5A delivered, frame_err=0.
